// File: rtl/mux_scan_n1.sv
// Registered N:1 bit selector with a manual mode and a divided auto-scan sequencer.
// Optional macro MUX_SCAN_DIR_EN adds a scan_dir input for down-counting scans.
module mux_scan_n1 #(
  parameter int N     = 35,
  parameter int SEL_W = 6,
  parameter int DIV   = 1000,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     data_in,
  input  logic             mode,
  input  logic             enable,
  input  logic [SEL_W-1:0] sel_in,
`ifdef MUX_SCAN_DIR_EN
  input  logic             scan_dir,
`endif
  output logic             out_bit,
  output logic [SEL_W-1:0] cur_sel,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  localparam logic [SEL_W-1:0] LAST     = SEL_W'(N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t             r_state, w_state_next;
  logic [DIV_W-1:0]   r_div, w_div_next;
  logic [SEL_W-1:0]   r_sel, w_sel_next;
  logic               r_out, w_out_next;
  logic               r_step, w_step_next;
  logic               r_wrap, w_wrap_next;
  logic               r_err, w_err_next;

  // Zero-padded copy of data_in so any SEL_W-bit index is in range.
  logic [2**SEL_W-1:0] w_data_pad;
  generate
    for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_pad
      if (gi < N) begin : g_bit
        assign w_data_pad[gi] = data_in[gi];
      end else begin : g_zero
        assign w_data_pad[gi] = 1'b0;
      end
    end
  endgenerate

  logic             w_dir_down;
  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_next_idx;
  logic             w_is_wrap;

`ifdef MUX_SCAN_DIR_EN
  assign w_dir_down = scan_dir;
`else
  assign w_dir_down = 1'b0;
`endif

  assign w_start    = w_dir_down ? LAST : '0;
  assign w_is_wrap  = w_dir_down ? (r_sel == '0) : (r_sel == LAST);
  assign w_next_idx = w_dir_down ? ((r_sel == '0) ? LAST : r_sel - SEL_W'(1))
                                 : ((r_sel == LAST) ? '0 : r_sel + SEL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MANUAL;
      r_div   <= '0;
      r_sel   <= '0;
      r_out   <= 1'b0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_div   <= w_div_next;
      r_sel   <= w_sel_next;
      r_out   <= w_out_next;
      r_step  <= w_step_next;
      r_wrap  <= w_wrap_next;
      r_err   <= w_err_next;
    end
  end

  // r_state is the mode last applied on an enabled edge, so a mode change made
  // while frozen still triggers its entry actions once enable returns.
  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div;
    w_sel_next   = r_sel;
    w_out_next   = r_out;
    w_step_next  = 1'b0;
    w_wrap_next  = 1'b0;
    w_err_next   = r_err;
    if (enable) begin
      w_state_next = mode ? SCAN : MANUAL;
      if (!mode) begin
        w_div_next = '0;
        w_sel_next = sel_in;
        if (sel_in > LAST) begin
          w_out_next = 1'b0;
          w_err_next = 1'b1;
        end else begin
          w_out_next = w_data_pad[sel_in];
          w_err_next = 1'b0;
        end
      end else if (r_state == MANUAL) begin
        w_div_next = '0;
        w_sel_next = w_start;
        w_out_next = w_data_pad[w_start];
        w_err_next = 1'b0;
      end else begin
        w_err_next = 1'b0;
        if (r_div == DIV_LAST) begin
          w_div_next  = '0;
          w_sel_next  = w_next_idx;
          w_out_next  = w_data_pad[w_next_idx];
          w_step_next = 1'b1;
          w_wrap_next = w_is_wrap;
        end else begin
          w_div_next = r_div + DIV_W'(1);
          w_out_next = w_data_pad[r_sel];
        end
      end
    end
  end

  assign out_bit = r_out;
  assign cur_sel = r_sel;
  assign step    = r_step;
  assign wrap    = r_wrap;
  assign err     = r_err;

endmodule
